// File: rtl/icash_pkg.sv
// Shared instruction-cache definitions: default geometry and loader state encoding.
package icash_pkg;

  // Default geometry shared with the instruction memory (4096 bits as 128 x 32).
  localparam int unsigned ICASH_DATA_WIDTH = 32;
  localparam int unsigned ICASH_ADDR_WIDTH = 7;

  // Loader state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } loader_state_e;

endpackage

// File: rtl/icash_loader_csum.sv
// Wrapping sum of accepted load words; cleared at the start of each load.
module icash_loader_csum
  import icash_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ICASH_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] sum
);

  // Accumulate on enable; clear has priority so a new load starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + data;
    end
  end

endmodule

// File: rtl/icash_loader.sv
// Instruction cache loader: write-side master that streams words into the
// instruction memory at incrementing, wrapping addresses.
// Optional feature: define ICASH_LOADER_CHECKSUM_EN to build the load checksum;
// otherwise o_checksum is tied to zero.
module icash_loader
  import icash_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = ICASH_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = ICASH_ADDR_WIDTH,
  parameter int unsigned COUNT_WIDTH = ADDR_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [ADDR_WIDTH-1:0]  i_base_addr,
  input  logic [COUNT_WIDTH-1:0] i_num_words,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   s_ready,
  output logic                   o_write_req,
  output logic [ADDR_WIDTH-1:0]  o_write_addr,
  output logic [DATA_WIDTH-1:0]  o_write_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [DATA_WIDTH-1:0]  o_checksum
);

  loader_state_e          state;
  loader_state_e          state_next;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   start_acc;
  logic                   beat;
  logic                   last_beat;
  logic                   busy_d;
  logic                   done_d;

  // Handshake decode: ready depends on state only, never on s_valid.
  assign s_ready   = (state == S_LOAD);
  assign start_acc = (state == S_IDLE) && i_start;
  assign beat      = s_ready && s_valid;
  assign last_beat = beat && (remaining_q == COUNT_WIDTH'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and next values of the registered status outputs.
  always_comb begin
    state_next = state;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_next = (i_num_words == '0) ? S_DRAIN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (last_beat) begin
          state_next = S_DRAIN;
        end
      end
      // The last write is presented during DRAIN; the memory commits it at
      // the end of DONE because it registers its write inputs once.
      S_DRAIN: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    busy_d = (state_next != S_IDLE);
    done_d = (state_next == S_DONE);
  end

  // Load bookkeeping and registered memory write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_q  <= '0;
      addr_q       <= '0;
      o_write_req  <= 1'b0;
      o_write_addr <= '0;
      o_write_data <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_write_req <= beat;
      o_busy      <= busy_d;
      o_done      <= done_d;
      if (start_acc) begin
        remaining_q <= i_num_words;
        addr_q      <= i_base_addr;
      end else if (beat) begin
        remaining_q  <= remaining_q - COUNT_WIDTH'(1);
        addr_q       <= addr_q + ADDR_WIDTH'(1);
        o_write_addr <= addr_q;
        o_write_data <= s_data;
      end
    end
  end

`ifdef ICASH_LOADER_CHECKSUM_EN
  // Running checksum of every accepted word of the current load.
  icash_loader_csum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_csum (
    .clk   (clk),
    .reset (reset),
    .clr   (start_acc),
    .en    (beat),
    .data  (s_data),
    .sum   (o_checksum)
  );
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_icash_loader.sv
// Self-checking bench for icash_loader: randomized and directed loads checked
// against a word-list model and a bench-side memory with one-cycle write latency.
module tb_icash_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [6:0]  i_base_addr;
  logic [7:0]  i_num_words;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        o_write_req;
  logic [6:0]  o_write_addr;
  logic [31:0] o_write_data;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_checksum;

  icash_loader dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_num_words  (i_num_words),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .o_write_req  (o_write_req),
    .o_write_addr (o_write_addr),
    .o_write_data (o_write_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_checksum   (o_checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed write pulses and done pulses.
  int          wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          done_count = 0;
  int          done_cyc   = -1;

  always @(negedge clk) begin
    if (o_write_req === 1'b1) begin
      wq_addr.push_back(int'(o_write_addr));
      wq_data.push_back(o_write_data);
      wq_cyc.push_back(cyc);
    end
    if (o_done === 1'b1) begin
      done_count = done_count + 1;
      done_cyc   = cyc;
    end
  end

  // Memory model: write inputs registered one cycle, then written.
  logic [31:0] mem [128];
  logic        st_v = 1'b0;
  logic [6:0]  st_a;
  logic [31:0] st_d;

  always @(posedge clk) begin
    if (st_v) mem[st_a] <= st_d;
    st_v <= o_write_req;
    st_a <= o_write_addr;
    st_d <= o_write_data;
  end

  // Words to be streamed by the next load.
  logic [31:0] tw[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_sum(input int n);
    logic [31:0] s = 32'h0;
    for (int i = 0; i < n; i++) s = s + tw[i];
`ifdef ICASH_LOADER_CHECKSUM_EN
    return s;
`else
    return 32'h0;
`endif
  endfunction

  // Drives one load. mode: 0 back-to-back, 1 alternating valid, 2 random valid.
  // interfere_at: cycle index of an extra i_start pulse during LOAD (-1 none).
  // reset_at: accepted-word count at which reset is pulsed (-1 none).
  task automatic drive_load(input int base, input int n, input int mode,
                            input bit hold_after, input int interfere_at,
                            input int reset_at, output int start_c,
                            output bit timeout, output logic busy1,
                            output logic ready1);
    int  idx = 0;
    int  t   = 0;
    bit  v;
    bit  acc;
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    done_count  = 0;
    done_cyc    = -1;
    timeout     = 1'b0;
    i_base_addr = 7'(base);
    i_num_words = 8'(n);
    i_start     = 1'b1;
    start_c     = cyc;
    tick();
    i_start     = 1'b0;
    i_base_addr = 7'($urandom);
    i_num_words = 8'($urandom);
    busy1       = o_busy;
    ready1      = s_ready;
    while (idx < n && t < 2000) begin
      if (reset_at >= 0 && idx == reset_at) begin
        s_valid = 1'b0;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        return;
      end
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (t % 2) == 1;
      else                v = ($urandom_range(0, 2) != 0);
      i_start = (t == interfere_at);
      s_valid = v;
      s_data  = v ? tw[idx] : $urandom;
      acc     = v && (s_ready === 1'b1);
      tick();
      if (acc) idx++;
      t++;
    end
    i_start = 1'b0;
    if (hold_after) begin
      s_valid = 1'b1;
      s_data  = $urandom;
    end else begin
      s_valid = 1'b0;
    end
    if (idx < n) timeout = 1'b1;
    t = 0;
    while (done_count == 0 && t < 40) begin
      tick();
      t++;
    end
    if (done_count == 0) timeout = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; i_start = 1'b0; i_base_addr = '0; i_num_words = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) tick();
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    total++; if (o_write_req !== 1'b0) begin bad++; $display("FAIL reset_write_req got=%b exp=0", o_write_req); end
    total++; if (o_write_addr !== 7'd0) begin bad++; $display("FAIL reset_write_addr got=%0d exp=0", o_write_addr); end
    total++; if (o_write_data !== 32'd0) begin bad++; $display("FAIL reset_write_data got=%h exp=0", o_write_data); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", o_done); end
    total++; if (o_checksum !== 32'd0) begin bad++; $display("FAIL reset_checksum got=%h exp=0", o_checksum); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int sc; bit to; logic b1, r1; logic [31:0] cs;
    tw = '{32'h11, 32'h22, 32'h33, 32'h44};
    drive_load(0, 4, 0, 1'b0, -1, -1, sc, to, b1, r1);
    total++; if (to) begin bad++; $display("FAIL basic_timeout got=1 exp=0"); end
    total++; if (b1 !== 1'b1 || r1 !== 1'b1) begin bad++; $display("FAIL basic_busy_ready_s1 got=%b%b exp=11", b1, r1); end
    total++; if (wq_addr.size() != 4) begin bad++; $display("FAIL basic_nwrites got=%0d exp=4", wq_addr.size()); end
    for (int k = 0; k < wq_addr.size() && k < 4; k++) begin
      total++;
      if (wq_addr[k] != k || wq_data[k] !== tw[k] || wq_cyc[k] != sc + 2 + k) begin
        bad++;
        $display("FAIL basic_write[%0d] got=a%0d d%h c%0d exp=a%0d d%h c%0d",
                 k, wq_addr[k], wq_data[k], wq_cyc[k], k, tw[k], sc + 2 + k);
      end
    end
    total++; if (done_cyc != sc + 6) begin bad++; $display("FAIL basic_done_cyc got=%0d exp=%0d", done_cyc, sc + 6); end
    total++; if (o_busy !== 1'b0 || s_ready !== 1'b0) begin bad++; $display("FAIL basic_idle got=busy%b ready%b exp=00", o_busy, s_ready); end
    for (int k = 0; k < 4; k++) begin
      total++; if (mem[k] !== tw[k]) begin bad++; $display("FAIL basic_mem[%0d] got=%h exp=%h", k, mem[k], tw[k]); end
    end
`ifdef ICASH_LOADER_CHECKSUM_EN
    cs = 32'hAA;
`else
    cs = 32'h0;
`endif
    repeat (2) tick();
    total++; if (o_checksum !== cs) begin bad++; $display("FAIL basic_checksum got=%h exp=%h", o_checksum, cs); end
  endtask

  task automatic test_wrap;
    int sc; bit to; logic b1, r1;
    tw = '{$urandom, $urandom, $urandom, $urandom};
    drive_load(126, 4, 0, 1'b0, -1, -1, sc, to, b1, r1);
    total++; if (to || wq_addr.size() != 4) begin bad++; $display("FAIL wrap_nwrites got=%0d exp=4 timeout=%0d", wq_addr.size(), to); end
    for (int k = 0; k < wq_addr.size() && k < 4; k++) begin
      total++;
      if (wq_addr[k] != (126 + k) % 128 || wq_data[k] !== tw[k]) begin
        bad++;
        $display("FAIL wrap_write[%0d] got=a%0d d%h exp=a%0d d%h", k, wq_addr[k], wq_data[k], (126 + k) % 128, tw[k]);
      end
    end
  endtask

  task automatic test_stall;
    int sc; bit to; logic b1, r1; int last;
    tw = '{$urandom, $urandom, $urandom};
    drive_load(40, 3, 1, 1'b1, -1, -1, sc, to, b1, r1);
    repeat (3) tick();
    s_valid = 1'b0;
    total++; if (to || wq_addr.size() != 3) begin bad++; $display("FAIL stall_nwrites got=%0d exp=3 timeout=%0d", wq_addr.size(), to); end
    for (int k = 0; k < wq_addr.size() && k < 3; k++) begin
      total++;
      if (wq_addr[k] != 40 + k || wq_data[k] !== tw[k] || (k > 0 && wq_cyc[k] != wq_cyc[k-1] + 2)) begin
        bad++;
        $display("FAIL stall_write[%0d] got=a%0d d%h c%0d exp=a%0d d%h", k, wq_addr[k], wq_data[k], wq_cyc[k], 40 + k, tw[k]);
      end
    end
    last = (wq_cyc.size() > 0) ? wq_cyc[wq_cyc.size()-1] : -100;
    total++; if (done_cyc != last + 1 || done_count != 1) begin bad++; $display("FAIL stall_done got=c%0d n%0d exp=c%0d n1", done_cyc, done_count, last + 1); end
  endtask

  task automatic test_zero_and_ignored_start;
    int sc; bit to; logic b1, r1; int base;
    tw.delete();
    drive_load(9, 0, 0, 1'b0, -1, -1, sc, to, b1, r1);
    total++; if (wq_addr.size() != 0) begin bad++; $display("FAIL zero_nwrites got=%0d exp=0", wq_addr.size()); end
    total++; if (to || done_cyc != sc + 2) begin bad++; $display("FAIL zero_done_cyc got=%0d exp=%0d", done_cyc, sc + 2); end
    total++; if (b1 !== 1'b1 || r1 !== 1'b0) begin bad++; $display("FAIL zero_busy_ready_s1 got=%b%b exp=10", b1, r1); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL zero_idle_busy got=%b exp=0", o_busy); end
    base = $urandom_range(0, 127);
    tw = '{$urandom, $urandom, $urandom, $urandom, $urandom};
    drive_load(base, 5, 0, 1'b0, 2, -1, sc, to, b1, r1);
    total++; if (to || wq_addr.size() != 5) begin bad++; $display("FAIL ignstart_nwrites got=%0d exp=5 timeout=%0d", wq_addr.size(), to); end
    for (int k = 0; k < wq_addr.size() && k < 5; k++) begin
      total++;
      if (wq_addr[k] != (base + k) % 128 || wq_data[k] !== tw[k]) begin
        bad++;
        $display("FAIL ignstart_write[%0d] got=a%0d d%h exp=a%0d d%h", k, wq_addr[k], wq_data[k], (base + k) % 128, tw[k]);
      end
    end
    total++; if (done_count != 1) begin bad++; $display("FAIL ignstart_done_count got=%0d exp=1", done_count); end
  endtask

  task automatic test_reset_mid_load;
    int sc; bit to; logic b1, r1;
    tw = '{$urandom, $urandom, $urandom, $urandom, $urandom};
    drive_load(70, 5, 0, 1'b0, -1, 2, sc, to, b1, r1);
    total++;
    if (s_ready !== 1'b0 || o_write_req !== 1'b0 || o_write_addr !== 7'd0 || o_write_data !== 32'd0 ||
        o_busy !== 1'b0 || o_done !== 1'b0 || o_checksum !== 32'd0) begin
      bad++;
      $display("FAIL midreset_outputs got=r%b w%b a%0d d%h b%b dn%b cs%h exp=all zero",
               s_ready, o_write_req, o_write_addr, o_write_data, o_busy, o_done, o_checksum);
    end
    tw = '{$urandom, $urandom};
    drive_load(20, 2, 0, 1'b0, -1, -1, sc, to, b1, r1);
    total++; if (to || wq_addr.size() != 2) begin bad++; $display("FAIL midreset_fresh_nwrites got=%0d exp=2 timeout=%0d", wq_addr.size(), to); end
    for (int k = 0; k < wq_addr.size() && k < 2; k++) begin
      total++;
      if (wq_addr[k] != 20 + k || wq_data[k] !== tw[k]) begin
        bad++;
        $display("FAIL midreset_fresh_write[%0d] got=a%0d d%h exp=a%0d d%h", k, wq_addr[k], wq_data[k], 20 + k, tw[k]);
      end
    end
    total++; if (o_checksum !== model_sum(2)) begin bad++; $display("FAIL midreset_checksum got=%h exp=%h", o_checksum, model_sum(2)); end
  endtask

  task automatic test_random_loads;
    int sc; bit to; logic b1, r1; int base; int n; int last;
    for (int it = 0; it < 8; it++) begin
      base = $urandom_range(0, 127);
      n    = $urandom_range(1, 24);
      tw.delete();
      for (int i = 0; i < n; i++) tw.push_back($urandom);
      drive_load(base, n, 2, 1'b0, -1, -1, sc, to, b1, r1);
      total++; if (to || wq_addr.size() != n) begin bad++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d timeout=%0d", it, wq_addr.size(), n, to); end
      for (int k = 0; k < wq_addr.size() && k < n; k++) begin
        total++;
        if (wq_addr[k] != (base + k) % 128 || wq_data[k] !== tw[k]) begin
          bad++;
          $display("FAIL rand%0d_write[%0d] got=a%0d d%h exp=a%0d d%h", it, k, wq_addr[k], wq_data[k], (base + k) % 128, tw[k]);
        end
        total++;
        if (mem[(base + k) % 128] !== tw[k]) begin
          bad++;
          $display("FAIL rand%0d_mem[%0d] got=%h exp=%h", it, (base + k) % 128, mem[(base + k) % 128], tw[k]);
        end
      end
      last = (wq_cyc.size() > 0) ? wq_cyc[wq_cyc.size()-1] : -100;
      total++; if (done_cyc != last + 1) begin bad++; $display("FAIL rand%0d_done_cyc got=%0d exp=%0d", it, done_cyc, last + 1); end
      total++; if (o_checksum !== model_sum(n)) begin bad++; $display("FAIL rand%0d_checksum got=%h exp=%h", it, o_checksum, model_sum(n)); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rand%0d_idle_busy got=%b exp=0", it, o_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_and_ignored_start();
    test_reset_mid_load();
    test_random_loads();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icash_loader.md
# icash_loader

Instruction loader: the write-side master for the instruction cache memory. It accepts a load command (base address, word count) from the host/control path, then takes instruction words from a valid/ready stream and issues one `o_write_req` pulse with address and data for each word, using incrementing, wrapping addresses. `o_done` is asserted only after the final word has been committed inside the memory. The memory registers its write inputs for one cycle before writing.

## Interface
Parameters:
- `DATA_WIDTH`, 32, instruction word width; must match the memory.
- `ADDR_WIDTH`, 7, memory word-address width (4096 bits / 32).
- `COUNT_WIDTH`, `ADDR_WIDTH+1`, width of the word-count field; allows a full-memory load.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_start`  in  1  one-cycle load command; sampled only in IDLE.
- `i_base_addr`  in  ADDR_WIDTH  first word address; captured with `i_start`.
- `i_num_words`  in  COUNT_WIDTH  number of words to load; captured with `i_start`.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  DATA_WIDTH  stream word.
- `s_ready`  out  1  loader accepts a word this cycle.
- `o_write_req`  out  1  memory write strobe; one cycle per word.
- `o_write_addr`  out  ADDR_WIDTH  memory write address.
- `o_write_data`  out  DATA_WIDTH  memory write data.
- `o_busy`  out  1  high from the cycle after an accepted `i_start` until the return to IDLE.
- `o_done`  out  1  one-cycle pulse; all words are committed in the memory.
- `o_checksum`  out  DATA_WIDTH  load checksum (see Configuration).

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
  - **IDLE**: a high `i_start` captures base and count, clears the word counter and checksum, and moves to LOAD. If `i_num_words==0`, the block moves directly to DRAIN instead.
  - **LOAD**: `s_ready`=1. Each beat with `s_valid&&s_ready` is one accepted word. The beat accepted with `remaining==1` moves the block to DRAIN.
  - **DRAIN**: lasts one cycle, then DONE.
  - **DONE**: `o_done`=1 for one cycle, then IDLE.
- `s_ready` is a combinational decode of state==LOAD only; it never depends on `s_valid`.
- Outputs `o_write_*` are registered. A word accepted at edge T gives `o_write_req`=1 in the cycle after T, with `o_write_addr`=base+k mod 2^ADDR_WIDTH (k = beat index from 0) and `o_write_data`=the word.
- Address arithmetic is ADDR_WIDTH wide and wraps silently. A load of more than 2^ADDR_WIDTH words overwrites earlier entries; this is legal.
- `i_start` outside IDLE is ignored; no queueing.
- `s_valid` outside LOAD is ignored; no word is consumed.
- Reset (including mid-load): state IDLE, counter 0, all outputs 0. Memory contents already written are not rolled back.

## Timing
- Reset values: `s_ready`=0, `o_write_req`=0, `o_write_addr`=0, `o_write_data`=0, `o_busy`=0, `o_done`=0, `o_checksum`=0.
- `i_start` at edge S → LOAD (`s_ready`=1, `o_busy`=1) from cycle S+1.
- Full throughput: one word per cycle while `s_valid` is held. Stalls of `s_valid` insert gaps with `o_write_req`=0.
- If the final `o_write_req` is high in cycle C:
  - DRAIN is in cycle C (the same cycle the last write is presented).
  - `o_done` is high in cycle C+1. The memory commits the word at the edge ending C+1, because its write inputs are registered for one cycle before the write.
  - IDLE, with `o_busy`=0, from C+2.
  - A fetch read issued after `o_done` sees the new data.
- Zero-word load: `i_start` at S → DRAIN at S+1, `o_done` at S+2, no write pulses.
- A new `i_start` is accepted in the first IDLE cycle after DONE.

## Configuration
- `ICASH_LOADER_CHECKSUM_EN` defined: `o_checksum` is the DATA_WIDTH-wide wrapping sum of all accepted words.
  - Cleared on an accepted `i_start`.
  - Holds its final value from the `o_done` cycle until the next `i_start` or reset.
- Not defined: the accumulator is not synthesized; `o_checksum` is tied to 0. The port list is unchanged.

## Structure
- Shared package `icash_pkg`:
  - State encoding localparams (IDLE/LOAD/DRAIN/DONE).
  - Default `DATA_WIDTH`/`ADDR_WIDTH` constants, shared with the memory.
- Sub-module `icash_loader_csum`: accumulator with clear/enable inputs, instantiated only under `ICASH_LOADER_CHECKSUM_EN`.
- Everything else is in the top module.

## Test plan
- Reset, then base=0, count=4, words 0x11,0x22,0x33,0x44 streamed back-to-back → writes at addr 0..3 on 4 consecutive cycles; `o_done` 1 cycle after the last `o_write_req`; memory read-back matches; checksum=0xAA (macro on) or 0 (macro off).
- base=126, count=4 → write addresses 126,127,0,1 (wrap).
- count=3 with `s_valid` low on alternating cycles → exactly 3 write pulses with gaps; `o_done` 1 cycle after the 3rd; `s_valid` after DRAIN is not consumed.
- count=0 → no `o_write_req`; `o_done` 2 cycles after `i_start`; a second `i_start` during LOAD is ignored (address sequence unaffected).
- `reset` asserted after 2 of 5 words → next cycle all outputs 0, state IDLE; a fresh load of 2 words completes normally.
